// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: operand width, FSM encodings
// and the word carried down each lane's skew line.
package systolic_feeder_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [1:0] FEED_IDLE  = 2'd0;
  localparam logic [1:0] FEED_RUN   = 2'd1;
  localparam logic [1:0] FEED_FLUSH = 2'd2;

  typedef struct packed {
    logic                  clr;
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } lane_word_t;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth register chain used as one lane's skew delay line.
module systolic_feeder_skew_line
  import systolic_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = $bits(lane_word_t)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds one edge of a systolic array: accepts unskewed operand vectors for a tile of
// k_len beats and emits them diagonally skewed, with a clear on the tile's first beat.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N       = 4,
  parameter int K_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N*DATA_WIDTH-1:0] in_data_i,
  output logic [N*DATA_WIDTH-1:0] src_o,
  output logic [N-1:0]            clr_o,
  output logic [N-1:0]            vld_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int FCW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
  logic               first_q, first_d;
  logic               done_q, done_d;
  logic               accept;

  assign accept = (state_q == FEED_RUN) && in_valid_i;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    first_d     = first_q;
    done_d      = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        // The done cycle is still the tail of the previous tile, so a start there is dropped.
        if (start_i && (k_len_i != '0) && !done_q) begin
          state_d    = FEED_RUN;
          k_len_d    = k_len_i;
          beat_cnt_d = '0;
          first_d    = 1'b1;
        end
      end
      FEED_RUN: begin
        if (accept) begin
          first_d    = 1'b0;
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          if (beat_cnt_q == k_len_q - K_WIDTH'(1)) begin
            state_d     = FEED_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FEED_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FCW'(1);
        if (flush_cnt_q == FCW'(N - 1)) begin
          state_d = FEED_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FEED_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      first_q     <= first_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o = (state_q == FEED_RUN);
  assign busy_o     = (state_q != FEED_IDLE);
  assign done_o     = done_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    lane_word_t w_in, w_out;

    // Bubbles, idle and flush cycles all inject an all-zero word.
    assign w_in = accept ? '{clr: first_q, vld: 1'b1,
                             data: in_data_i[gi*DATA_WIDTH +: DATA_WIDTH]} : '0;

    systolic_feeder_skew_line #(
      .DEPTH(gi + 1),
      .WIDTH($bits(lane_word_t))
    ) u_skew (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (w_in),
      .q_o   (w_out)
    );

    assign src_o[gi*DATA_WIDTH +: DATA_WIDTH] = w_out.data;
    assign vld_o[gi]                          = w_out.vld;
    assign clr_o[gi]                          = w_out.clr;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4, 16-bit lanes): a directed vector table,
// hand-written corner sequences and random traffic, all checked against a history model.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int MAXC = 8192;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    k_len_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [N*DW-1:0] in_data_i = '0;
  logic [N*DW-1:0] src_o;
  logic [N-1:0]  clr_o, vld_o;
  logic          busy_o, done_o;

  systolic_feeder #(.N(N), .K_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .src_o(src_o), .clr_o(clr_o), .vld_o(vld_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: which beat entered the array in each cycle, plus tile bookkeeping.
  int   c = 0;
  bit   feeding = 0;
  int   left = 0;
  bit   first_m = 0;
  int   done_at = -1;
  bit   inj_v [MAXC];
  bit   inj_c [MAXC];
  logic [N*DW-1:0] inj_d [MAXC];

  typedef struct packed {
    logic          start;
    logic [7:0]    klen;
    logic          valid;
    logic [N*DW-1:0] data;
    logic [N*DW-1:0] src;
    logic [N-1:0]  clr;
    logic [N-1:0]  vld;
    logic          busy;
    logic          ready;
    logic          done;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic check_model();
    logic [N*DW-1:0] es = '0;
    logic [N-1:0] ec = '0;
    logic [N-1:0] ev = '0;
    for (int i = 0; i < N; i++) begin
      int j = c - 1 - i;
      if (j >= 0 && inj_v[j]) begin
        es[i*DW +: DW] = inj_d[j][i*DW +: DW];
        ev[i] = 1'b1;
        ec[i] = inj_c[j];
      end
    end
    chk("model_src", 64'(src_o), 64'(es));
    chk("model_clr", 64'(clr_o), 64'(ec));
    chk("model_vld", 64'(vld_o), 64'(ev));
    chk("model_busy", 64'(busy_o), 64'(feeding || (c < done_at)));
    chk("model_ready", 64'(in_ready_o), 64'(feeding));
    chk("model_done", 64'(done_o), 64'(c == done_at));
  endtask

  // One clock cycle: check outputs of cycle c, drive its inputs, advance the model.
  task automatic step(input logic s, input logic [7:0] kl, input logic v, input logic [N*DW-1:0] d);
    bit acc;
    if (c >= MAXC) begin
      $display("FAIL cycle_budget cycle %0d: got %0d expected below %0d", c, c, MAXC);
      $fatal(1);
    end
    check_model();
    start_i = s; k_len_i = kl; in_valid_i = v; in_data_i = d;
    acc = feeding && v;
    inj_v[c] = acc;
    inj_c[c] = acc && first_m;
    inj_d[c] = d;
    if (acc) begin
      first_m = 0;
      left--;
      if (left == 0) begin
        feeding = 0;
        done_at = c + N + 1;
      end
    end else if (!feeding && c > done_at && s && kl != 0) begin
      feeding = 1;
      left = int'(kl);
      first_m = 1;
    end
    @(negedge clk_i);
    c++;
  endtask

  task automatic do_reset();
    start_i = 0; in_valid_i = 0; rst_ni = 0;
    #1;
    chk("rst_src", 64'(src_o), 64'd0);
    chk("rst_clr", 64'(clr_o), 64'd0);
    chk("rst_vld", 64'(vld_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    for (int i = 0; i < MAXC; i++) begin
      inj_v[i] = 0;
      inj_c[i] = 0;
    end
    feeding = 0; left = 0; first_m = 0; done_at = -1;
    @(negedge clk_i);
    rst_ni = 1;
    c++;
  endtask

  task automatic idle_until_done(input string nm, input int exp_cycle);
    int seen = -1;
    for (int i = 0; i < 12; i++) begin
      if (done_o && seen < 0) seen = c;
      step(0, 0, 0, '0);
    end
    chk(nm, 64'(seen), 64'(exp_cycle));
  endtask

  function automatic logic [N*DW-1:0] vec4(input int a, input int b, input int x, input int y);
    return {16'(y), 16'(x), 16'(b), 16'(a)};
  endfunction

  initial begin
    int lb, sc, dn, cb;
    int cnt [N];

    tbl[0] = '{1'b1, 8'd3, 1'b0, 64'h0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 64'h0004_0003_0002_0001, 64'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b1, 64'h0008_0007_0006_0005, 64'h0000_0000_0000_0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 64'h000C_000B_000A_0009, 64'h0000_0000_0002_0005, 4'b0010, 4'b0011, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h0000_0003_0006_0009, 4'b0100, 4'b0111, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h0004_0007_000A_0000, 4'b1000, 4'b1110, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h0008_000B_0000_0000, 4'b0000, 4'b1100, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h000C_0000_0000_0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'd0, 1'b0, 64'h0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

    @(negedge clk_i);
    do_reset();

    // Directed single tile from the vector table.
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("tbl%0d_src", r), 64'(src_o), 64'(tbl[r].src));
      chk($sformatf("tbl%0d_clr", r), 64'(clr_o), 64'(tbl[r].clr));
      chk($sformatf("tbl%0d_vld", r), 64'(vld_o), 64'(tbl[r].vld));
      chk($sformatf("tbl%0d_busy", r), 64'(busy_o), 64'(tbl[r].busy));
      chk($sformatf("tbl%0d_ready", r), 64'(in_ready_o), 64'(tbl[r].ready));
      chk($sformatf("tbl%0d_done", r), 64'(done_o), 64'(tbl[r].done));
      $display("vector %0d applied at cycle %0d", r, c);
      step(tbl[r].start, tbl[r].klen, tbl[r].valid, tbl[r].data);
    end

    // Bubble in the middle of a two-beat tile.
    step(1, 2, 0, '0);
    step(0, 0, 1, vec4(11, 12, 13, 14));
    step(0, 0, 0, vec4(99, 99, 99, 99));
    lb = c;
    step(0, 0, 1, vec4(21, 22, 23, 24));
    idle_until_done("bubble_done_cycle", lb + N + 1);
    $display("bubble tile done, last beat at cycle %0d", lb);

    // Zero-length start is ignored.
    step(1, 0, 1, '0);
    chk("zero_len_busy", 64'(busy_o), 64'd0);
    chk("zero_len_ready", 64'(in_ready_o), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, '0);
    $display("zero-length start checked at cycle %0d", c);

    // Start while busy must not relatch the length.
    step(1, 3, 0, '0);
    step(0, 0, 1, vec4(1, 1, 1, 1));
    step(1, 9, 1, vec4(2, 2, 2, 2));
    step(0, 0, 0, '0);
    lb = c;
    step(0, 0, 1, vec4(3, 3, 3, 3));
    chk("busy_start_ready_after", 64'(in_ready_o), 64'd0);
    idle_until_done("busy_start_done_cycle", lb + N + 1);
    $display("start-while-busy tile done, last beat at cycle %0d", lb);

    // Start held through flush and done: restart only the cycle after done.
    step(1, 1, 0, '0);
    cb = c;
    step(0, 0, 1, vec4(5, 6, 7, 8));
    for (int i = 0; i < 7; i++) step(1, 2, 0, '0);
    chk("restart_busy", 64'(busy_o), 64'd1);
    chk("restart_cycle_ready", 64'(in_ready_o), 64'd1);
    step(0, 0, 1, vec4(1, 2, 3, 4));
    lb = c;
    step(0, 0, 1, vec4(5, 6, 7, 8));
    idle_until_done("restart_done_cycle", lb + N + 1);
    $display("back-to-back restart checked, first tile beat at cycle %0d", cb);

    // Reset in the middle of a tile, then a clean tile.
    step(1, 5, 0, '0);
    step(0, 0, 1, vec4(7, 7, 7, 7));
    step(0, 0, 1, vec4(8, 8, 8, 8));
    do_reset();
    step(1, 2, 0, '0);
    step(0, 0, 1, vec4(31, 32, 33, 34));
    chk("post_rst_clr_lane0", 64'(clr_o[0]), 64'd1);
    chk("post_rst_src_lane0", 64'(src_o[DW-1:0]), 64'd31);
    lb = c;
    step(0, 0, 1, vec4(41, 42, 43, 44));
    idle_until_done("post_rst_done_cycle", lb + N + 1);
    $display("reset mid-tile checked at cycle %0d", c);

    // Maximum length tile, continuous beats.
    for (int i = 0; i < N; i++) cnt[i] = 0;
    dn = -1;
    sc = c;
    for (int i = 0; i < 262; i++) begin
      for (int l = 0; l < N; l++) cnt[l] += int'(vld_o[l]);
      if (done_o && dn < 0) dn = c;
      if (i == 0) step(1, 8'd255, 0, '0);
      else if (i <= 255) step(0, 0, 1, {$urandom, $urandom});
      else step(0, 0, 0, '0);
    end
    for (int l = 0; l < N; l++) chk($sformatf("max_vld_count_lane%0d", l), 64'(cnt[l]), 64'd255);
    chk("max_done_cycle", 64'(dn), 64'(sc + 260));
    $display("max-length tile started at cycle %0d, done seen at %0d", sc, dn);

    // Random traffic: random starts, lengths (including 0) and bubbles.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 6)),
           $urandom_range(0, 3) != 0, {$urandom, $urandom});
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, '0);
    $display("random traffic finished at cycle %0d", c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
